uart_led_cmd_ctrl: RTL and testbench
====================================

Name: uart_led_cmd_ctrl

Overview:
Command-driven LED/GPIO controller that sits between the uart_rx FIFO read port and the uart_tx FIFO write port. It is the parametrised successor to the single-byte echo/LED path.
- Parses 1- or 2-byte command frames.
- Applies write, set, clear or toggle operations to a NUM_LEDS-wide output register.
- Supports readback of the register.
- Returns an acknowledge, data or error byte for every frame.
- Recovers from a missing argument byte with a timeout.

Parameters:
DATA_WIDTH, 8, UART byte width; must be 8.
NUM_LEDS, 4, width of led_o; legal range 1..DATA_WIDTH.
TIMEOUT_CYCLES, 5_000_000, clk_i cycles allowed between opcode and argument byte; must be at least 2.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
rx_empty_i  input  1  rx FIFO empty
rx_ren_o  output  1  rx FIFO read strobe, one-cycle pulse
rx_data_i  input  DATA_WIDTH  rx FIFO data; valid in the cycle after rx_ren_o
tx_full_i  input  1  tx FIFO full
tx_wen_o  output  1  tx FIFO write strobe, one-cycle pulse
tx_data_o  output  DATA_WIDTH  response byte; valid while tx_wen_o=1
led_o  output  NUM_LEDS  LED register
busy_o  output  1  high whenever the FSM is not in IDLE
err_o  output  1  one-cycle pulse when an 'E' response is written

Behaviour:
- One clock; reset is synchronous and active-high.
  - rst_i=1 at a clk_i edge: FSM=IDLE, led_o=0, rx_ren_o=0, tx_wen_o=0, tx_data_o=0, err_o=0, timeout counter=0.
  - Reset mid-frame abandons the frame. No response is sent. Any partially read bytes are lost.
- Opcodes (ASCII):
  - 'W'=0x57: led <= arg.
  - 'S'=0x53: led <= led | arg.
  - 'C'=0x43: led <= led & ~arg.
  - 'T'=0x54: led <= led ^ arg.
  - 'R'=0x52: readback, no argument.
  - Any other byte: error.
- Width rules:
  - arg is truncated to arg[NUM_LEDS-1:0]; upper bits are ignored.
  - Readback response is led_o zero-extended to DATA_WIDTH.
- Responses:
  - 'K'=0x4B after a successful W/S/C/T.
  - The LED value for R.
  - 'E'=0x45 for an unknown opcode or a timeout.
- FSM states:
  - IDLE: if !rx_empty_i, pulse rx_ren_o and go to OP_LAT.
  - OP_LAT: capture rx_data_i as opcode.
    - R: load tx_data_o with the LED value, go to RESP.
    - W/S/C/T: clear the counter, go to ARG_WAIT.
    - Otherwise: load 'E', go to RESP.
  - ARG_WAIT: counter increments each cycle.
    - If !rx_empty_i: pulse rx_ren_o, go to ARG_LAT. Data takes priority if data arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1.
    - Else if counter==TIMEOUT_CYCLES-1: load 'E', go to RESP.
  - ARG_LAT: apply the operation to led_o (registered; new value visible the next cycle), load 'K', go to RESP.
  - RESP: while tx_full_i=1, hold with no write and no timeout. When tx_full_i=0, pulse tx_wen_o (plus err_o if the byte is 'E') and go to IDLE.
- Timing and flow control:
  - rx_ren_o is never asserted in OP_LAT, ARG_LAT or RESP, so the rx FIFO is never read when empty or double-read.
  - tx_wen_o is never asserted when tx_full_i=1.
  - Exactly one response byte is written per completed frame.
  - Latency for R with tx not full: rx_ren_o at cycle 0, tx_wen_o at cycle 2.
  - Latency for W with the argument already in the FIFO: opcode ren at 0, arg ren at 2, led_o update and 'K' load at 3, tx_wen_o at 4.
- Back-to-back frames are handled without loss. IDLE re-reads on the cycle after RESP completes.

Decomposition:
- Package uart_led_pkg:
  - state_t enum {IDLE, OP_LAT, ARG_WAIT, ARG_LAT, RESP}
  - opcode localparams OP_WRITE, OP_SET, OP_CLR, OP_TGL, OP_READ
  - response localparams RSP_ACK, RSP_ERR
- One natural sub-module: uart_led_timeout_cnt, a loadable counter with clear, enable and terminal-count outputs, sized $clog2(TIMEOUT_CYCLES).
- The top level (ties rx/tx FIFOs with tx_en/rx_en=1) instantiates uart_led_cmd_ctrl.

Test Plan:
1. Reset, then feed 0x57,0x0A with tx not full -> led_o=4'hA one cycle after the arg read; tx receives 0x4B; err_o never pulses.
2. led=4'hA, feed 'S',0x05 then 'C',0x02 then 'T',0xFF -> led_o goes 4'hF, then 4'hD, then 4'h2; tx receives 0x4B three times.
3. led=4'h6, feed 'R' -> tx_wen_o exactly 2 cycles after rx_ren_o with tx_data_o=0x06; led unchanged.
4. Feed 0x41 ('A') -> tx receives 0x45, err_o pulses once, led unchanged. The next 'W',0x03 gives led=4'h3 and 0x4B.
5. Feed 'W' only, keep rx empty for TIMEOUT_CYCLES (bench sets 16) -> 0x45 and err_o after 16 ARG_WAIT cycles, FSM back in IDLE. A late 0x09 is then treated as an opcode and gives 0x45.
6. Hold tx_full_i=1 for 50 cycles during RESP of 'W',0x01 -> no tx_wen_o while full and no timeout. Exactly one 0x4B after release. Asserting rst_i in ARG_WAIT instead -> led_o=0, busy_o=0, no response.

Source files
------------

// File: rtl/uart_led_pkg.sv
// Shared FSM state codes, command opcodes and response bytes for the UART LED command controller.
// Pure declarations: no logic, no latency, no flow control.
package uart_led_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t OP_LAT   = 3'd1;
    localparam state_t ARG_WAIT = 3'd2;
    localparam state_t ARG_LAT  = 3'd3;
    localparam state_t RESP     = 3'd4;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_SET   = 8'h53;
    localparam logic [7:0] OP_CLR   = 8'h43;
    localparam logic [7:0] OP_TGL   = 8'h54;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    function automatic logic is_arg_op(input logic [7:0] op);
        return op inside {OP_WRITE, OP_SET, OP_CLR, OP_TGL};
    endfunction

endpackage

// File: rtl/uart_led_timeout_cnt.sv
// Argument-wait timer: synchronous clear, count enable, terminal count at TIMEOUT_CYCLES-1.
// tc is combinational from the count register; no backpressure.
module uart_led_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned CW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Parses W/S/C/T/R command frames from the rx FIFO, updates the LED register and writes one reply byte.
// R replies 2 cycles after the opcode read, W/S/C/T 4 cycles; stalls in RESP while tx is full.
module uart_led_cmd_ctrl
    import uart_led_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_LEDS       = 4,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_empty_i,
    output logic                  rx_ren_o,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  tx_full_i,
    output logic                  tx_wen_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic [NUM_LEDS-1:0]   led_o,
    output logic                  busy_o,
    output logic                  err_o
);

    state_t                state;
    logic [DATA_WIDTH-1:0] opcode;
    logic                  resp_err;
    logic                  tmo;
    logic [NUM_LEDS-1:0]   arg;
    logic [DATA_WIDTH-1:0] led_ext;

    uart_led_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk (clk_i),
        .rst (rst_i),
        .clr (state == OP_LAT),
        .en  (state == ARG_WAIT),
        .tc  (tmo)
    );

    assign arg = rx_data_i[NUM_LEDS-1:0];

    always_comb begin
        led_ext                 = '0;
        led_ext[NUM_LEDS-1:0]   = led_o;
    end

    // Strobes are gated by reset so a FIFO byte is never popped while the FSM is being cleared.
    assign rx_ren_o = !rst_i && !rx_empty_i && ((state == IDLE) || (state == ARG_WAIT));
    assign tx_wen_o = !rst_i && (state == RESP) && !tx_full_i;
    assign err_o    = tx_wen_o && resp_err;
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            led_o     <= '0;
            tx_data_o <= '0;
            opcode    <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_empty_i) state <= OP_LAT;
                end
                OP_LAT: begin
                    opcode <= rx_data_i;
                    if (rx_data_i == OP_READ) begin
                        tx_data_o <= led_ext;
                        resp_err  <= 1'b0;
                        state     <= RESP;
                    end else if (is_arg_op(rx_data_i)) begin
                        state <= ARG_WAIT;
                    end else begin
                        tx_data_o <= RSP_ERR;
                        resp_err  <= 1'b1;
                        state     <= RESP;
                    end
                end
                ARG_WAIT: begin
                    // A byte arriving on the terminal-count cycle still wins over the timeout.
                    if (!rx_empty_i) begin
                        state <= ARG_LAT;
                    end else if (tmo) begin
                        tx_data_o <= RSP_ERR;
                        resp_err  <= 1'b1;
                        state     <= RESP;
                    end
                end
                ARG_LAT: begin
                    case (opcode)
                        OP_WRITE: led_o <= arg;
                        OP_SET:   led_o <= led_o | arg;
                        OP_CLR:   led_o <= led_o & ~arg;
                        default:  led_o <= led_o ^ arg;
                    endcase
                    tx_data_o <= RSP_ACK;
                    resp_err  <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    if (!tx_full_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Randomized and directed bench for uart_led_cmd_ctrl with queue-based rx/tx FIFO models and a frame-level LED model.
module tb_uart_led_cmd_ctrl;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_empty_i = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       tx_full_i = 1'b0;
    logic       rx_ren_o, tx_wen_o, busy_o, err_o;
    logic [7:0] tx_data_o;
    logic [3:0] led_o;

    uart_led_cmd_ctrl #(
        .DATA_WIDTH     (8),
        .NUM_LEDS       (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_empty_i (rx_empty_i),
        .rx_ren_o   (rx_ren_o),
        .rx_data_i  (rx_data_i),
        .tx_full_i  (tx_full_i),
        .tx_wen_o   (tx_wen_o),
        .tx_data_o  (tx_data_o),
        .led_o      (led_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int         ren_cyc[$];
    int         wen_cyc[$];
    int         led_chg[$];
    logic [3:0] led_vals[$];
    logic [3:0] led_prev = 4'h0;
    logic [3:0] mled = 4'h0;
    bit         ren_s = 1'b0;
    int cyc = 0, err_cnt = 0, err_viol = 0, full_viol = 0, underflow = 0;
    int n_cmp = 0, n_fail = 0;

    // rx FIFO model: pops on the sampled strobe, data valid the following cycle.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (ren_s) begin
            if (rx_q.size() == 0) underflow = underflow + 1;
            else rx_data_i = rx_q.pop_front();
        end
        rx_empty_i = (rx_q.size() == 0);
    end

    always @(negedge clk) begin
        #1;
        ren_s = rx_ren_o;
        if (rx_ren_o) ren_cyc.push_back(cyc);
        if (tx_wen_o) begin
            if (tx_full_i) full_viol = full_viol + 1;
            tx_log.push_back(tx_data_o);
            wen_cyc.push_back(cyc);
        end
        if (err_o) err_cnt = err_cnt + 1;
        if (err_o !== (tx_wen_o && tx_data_o == 8'h45)) err_viol = err_viol + 1;
        if (led_o !== led_prev) begin
            led_chg.push_back(cyc);
            led_vals.push_back(led_o);
            led_prev = led_o;
        end
    end

    // Frame-level reference: returns the expected reply and updates the model LED state.
    function automatic logic [7:0] ref_frame(input logic [7:0] op, input logic [7:0] arg);
        case (op)
            8'h57: begin mled = arg[3:0];          return 8'h4B; end
            8'h53: begin mled = mled | arg[3:0];   return 8'h4B; end
            8'h43: begin mled = mled & ~arg[3:0];  return 8'h4B; end
            8'h54: begin mled = mled ^ arg[3:0];   return 8'h4B; end
            8'h52: return {4'h0, mled};
            default: return 8'h45;
        endcase
    endfunction

    task automatic clear_logs();
        tx_log.delete(); ren_cyc.delete(); wen_cyc.delete();
        led_chg.delete(); led_vals.delete(); err_cnt = 0;
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (tx_log.size() >= n) break;
            @(negedge clk);
        end
        ok = (tx_log.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        logic [7:0] exp;
        repeat (2) @(negedge clk);
        rx_q.push_back(8'h52);
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_ren_o !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b want 0", rx_ren_o); end
        n_cmp++; if (led_o !== 4'h0) begin n_fail++; $display("FAIL reset_led: got %h want 0", led_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (tx_wen_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen_err: got %b%b want 00", tx_wen_o, err_o); end
        n_cmp++; if (tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_txdata: got %h want 00", tx_data_o); end
        clear_logs();
        rst_i = 1'b0;
        mled = 4'h0;
        exp = ref_frame(8'h52, 8'h00);
        wait_tx(1, 50, ok);
        n_cmp++; if (!ok || tx_log[0] !== exp) begin n_fail++; $display("FAIL reset_first_read: ok=%0d got %h want %h", ok, ok ? tx_log[0] : 8'hxx, exp); end
    endtask

    task automatic test_write();
        bit ok;
        logic [7:0] exp;
        clear_logs();
        rx_q.push_back(8'h57); rx_q.push_back(8'h0A);
        exp = ref_frame(8'h57, 8'h0A);
        wait_tx(1, 50, ok);
        n_cmp++; if (!ok || tx_log[0] !== exp) begin n_fail++; $display("FAIL write_resp: ok=%0d got %h want %h", ok, ok ? tx_log[0] : 8'hxx, exp); end
        n_cmp++; if (led_o !== mled) begin n_fail++; $display("FAIL write_led: got %h want %h", led_o, mled); end
        n_cmp++; if (ren_cyc.size() < 2 || ren_cyc[1] - ren_cyc[0] != 2) begin n_fail++; $display("FAIL write_arg_ren_lat: got %0d reads, want arg read 2 cycles after opcode", ren_cyc.size()); end
        n_cmp++; if (ren_cyc.size() < 1 || wen_cyc.size() < 1 || wen_cyc[0] - ren_cyc[0] != 4) begin n_fail++; $display("FAIL write_wen_lat: got %0d want 4", (ren_cyc.size() > 0 && wen_cyc.size() > 0) ? wen_cyc[0] - ren_cyc[0] : -1); end
        n_cmp++; if (ren_cyc.size() < 2 || led_chg.size() < 1 || led_chg[0] != ren_cyc[1] + 2) begin n_fail++; $display("FAIL write_led_timing: led change at %0d want %0d", led_chg.size() > 0 ? led_chg[0] : -1, ren_cyc.size() > 1 ? ren_cyc[1] + 2 : -1); end
        n_cmp++; if (err_cnt != 0) begin n_fail++; $display("FAIL write_err: got %0d pulses want 0", err_cnt); end
    endtask

    task automatic test_set_clr_tgl();
        bit ok;
        logic [7:0] ops [3] = '{8'h53, 8'h43, 8'h54};
        logic [7:0] args[3] = '{8'h05, 8'h02, 8'hFF};
        logic [7:0] exp[3];
        logic [3:0] eled[3];
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            rx_q.push_back(ops[i]); rx_q.push_back(args[i]);
            exp[i] = ref_frame(ops[i], args[i]);
            eled[i] = mled;
        end
        wait_tx(3, 100, ok);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (!ok || tx_log[i] !== exp[i]) begin n_fail++; $display("FAIL sct_resp%0d: got %h want %h", i, ok ? tx_log[i] : 8'hxx, exp[i]); end
            n_cmp++; if (led_vals.size() <= i || led_vals[i] !== eled[i]) begin n_fail++; $display("FAIL sct_led%0d: got %h want %h", i, led_vals.size() > i ? led_vals[i] : 4'hx, eled[i]); end
        end
        n_cmp++; if (err_cnt != 0) begin n_fail++; $display("FAIL sct_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_read();
        bit ok;
        logic [7:0] exp;
        clear_logs();
        rx_q.push_back(8'h57); rx_q.push_back(8'h06);
        exp = ref_frame(8'h57, 8'h06);
        wait_tx(1, 50, ok);
        clear_logs();
        rx_q.push_back(8'h52);
        exp = ref_frame(8'h52, 8'h00);
        wait_tx(1, 50, ok);
        n_cmp++; if (!ok || tx_log[0] !== exp) begin n_fail++; $display("FAIL read_data: got %h want %h", ok ? tx_log[0] : 8'hxx, exp); end
        n_cmp++; if (ren_cyc.size() < 1 || wen_cyc.size() < 1 || wen_cyc[0] - ren_cyc[0] != 2) begin n_fail++; $display("FAIL read_lat: got %0d want 2", (ren_cyc.size() > 0 && wen_cyc.size() > 0) ? wen_cyc[0] - ren_cyc[0] : -1); end
        n_cmp++; if (led_o !== mled || led_chg.size() != 0) begin n_fail++; $display("FAIL read_led: got %h (%0d changes) want %h", led_o, led_chg.size(), mled); end
    endtask

    task automatic test_unknown();
        bit ok;
        logic [7:0] exp;
        clear_logs();
        rx_q.push_back(8'h41);
        exp = ref_frame(8'h41, 8'h00);
        wait_tx(1, 50, ok);
        repeat (2) @(negedge clk);
        n_cmp++; if (!ok || tx_log[0] !== exp) begin n_fail++; $display("FAIL unk_resp: got %h want %h", ok ? tx_log[0] : 8'hxx, exp); end
        n_cmp++; if (err_cnt != 1) begin n_fail++; $display("FAIL unk_err: got %0d pulses want 1", err_cnt); end
        n_cmp++; if (led_o !== mled) begin n_fail++; $display("FAIL unk_led: got %h want %h", led_o, mled); end
        clear_logs();
        rx_q.push_back(8'h57); rx_q.push_back(8'h03);
        exp = ref_frame(8'h57, 8'h03);
        wait_tx(1, 50, ok);
        n_cmp++; if (!ok || tx_log[0] !== exp || led_o !== mled) begin n_fail++; $display("FAIL unk_recover: resp %h led %h want %h %h", ok ? tx_log[0] : 8'hxx, led_o, exp, mled); end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h57);
        wait_tx(1, 100, ok);
        n_cmp++; if (!ok || tx_log[0] !== 8'h45) begin n_fail++; $display("FAIL tmo_resp: got %h want 45", ok ? tx_log[0] : 8'hxx); end
        // opcode read, one latch cycle, TMO wait cycles, then the reply cycle
        n_cmp++; if (ren_cyc.size() < 1 || wen_cyc.size() < 1 || wen_cyc[0] - ren_cyc[0] != TMO + 2) begin n_fail++; $display("FAIL tmo_lat: got %0d want %0d", (ren_cyc.size() > 0 && wen_cyc.size() > 0) ? wen_cyc[0] - ren_cyc[0] : -1, TMO + 2); end
        n_cmp++; if (err_cnt != 1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL tmo_err_busy: err %0d busy %b want 1 0", err_cnt, busy_o); end
        n_cmp++; if (led_o !== mled) begin n_fail++; $display("FAIL tmo_led: got %h want %h", led_o, mled); end
        clear_logs();
        rx_q.push_back(8'h09);
        wait_tx(1, 50, ok);
        n_cmp++; if (!ok || tx_log[0] !== 8'h45) begin n_fail++; $display("FAIL tmo_late_byte: got %h want 45", ok ? tx_log[0] : 8'hxx); end
    endtask

    task automatic test_tx_full();
        bit ok;
        logic [7:0] exp;
        clear_logs();
        tx_full_i = 1'b1;
        rx_q.push_back(8'h57); rx_q.push_back(8'h01);
        exp = ref_frame(8'h57, 8'h01);
        repeat (50) @(negedge clk);
        n_cmp++; if (tx_log.size() != 0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL full_hold: writes %0d busy %b want 0 1", tx_log.size(), busy_o); end
        tx_full_i = 1'b0;
        wait_tx(1, 20, ok);
        repeat (10) @(negedge clk);
        n_cmp++; if (tx_log.size() != 1 || tx_log[0] !== exp) begin n_fail++; $display("FAIL full_release: writes %0d first %h want 1 %h", tx_log.size(), tx_log.size() > 0 ? tx_log[0] : 8'hxx, exp); end
        n_cmp++; if (led_o !== mled || err_cnt != 0) begin n_fail++; $display("FAIL full_led: got %h err %0d want %h 0", led_o, err_cnt, mled); end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        rx_q.push_back(8'h57);
        repeat (5) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy_o); end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        mled = 4'h0;
        n_cmp++; if (led_o !== mled || busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_state: led %h busy %b want %h 0", led_o, busy_o, mled); end
        repeat (30) @(negedge clk);
        n_cmp++; if (tx_log.size() != 0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resp: writes %0d busy %b want 0 0", tx_log.size(), busy_o); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 40;
        logic [7:0] legal[5] = '{8'h57, 8'h53, 8'h43, 8'h54, 8'h52};
        logic [7:0] exp[$];
        logic [7:0] op, arg;
        int n_err = 0;
        int bad = 0;
        clear_logs();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 8'($urandom_range(0, 255)); while (op inside {8'h57, 8'h53, 8'h43, 8'h54, 8'h52});
            end else begin
                op = legal[$urandom_range(0, 4)];
            end
            arg = 8'($urandom_range(0, 255));
            rx_q.push_back(op);
            if (op inside {8'h57, 8'h53, 8'h43, 8'h54}) rx_q.push_back(arg);
            exp.push_back(ref_frame(op, arg));
            if (exp[i] == 8'h45) n_err++;
        end
        for (int i = 0; i < 3000; i++) begin
            if (tx_log.size() >= N) break;
            tx_full_i = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        tx_full_i = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (tx_log.size() != N) begin n_fail++; $display("FAIL b2b_count: got %0d replies want %0d", tx_log.size(), N); end
        for (int i = 0; i < N && i < tx_log.size(); i++)
            if (tx_log[i] !== exp[i]) begin
                if (bad < 5) $display("FAIL b2b_resp%0d: got %h want %h", i, tx_log[i], exp[i]);
                bad++;
            end
        n_cmp++; if (bad != 0) n_fail++;
        n_cmp++; if (led_o !== mled) begin n_fail++; $display("FAIL b2b_led: got %h want %h", led_o, mled); end
        n_cmp++; if (err_cnt != n_err) begin n_fail++; $display("FAIL b2b_err: got %0d pulses want %0d", err_cnt, n_err); end
        n_cmp++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL b2b_rx_drain: %0d bytes left want 0", rx_q.size()); end
    endtask

    task automatic test_protocol();
        n_cmp++; if (underflow != 0) begin n_fail++; $display("FAIL proto_rx_underflow: got %0d want 0", underflow); end
        n_cmp++; if (full_viol != 0) begin n_fail++; $display("FAIL proto_tx_when_full: got %0d want 0", full_viol); end
        n_cmp++; if (err_viol != 0) begin n_fail++; $display("FAIL proto_err_pulse: got %0d bad cycles want 0", err_viol); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_set_clr_tgl();
        test_read();
        test_unknown();
        test_timeout();
        test_tx_full();
        test_reset_mid_frame();
        test_back_to_back();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
